// File: rtl/mtl_display_engine.sv
// LCD timing and pixel engine for MTL-class panels: raster counters, early pixel fetch,
// loading/run mode FSM and built-in sources, with HD/VD/DE delayed to match the fetch latency.
module mtl_display_engine #(
  parameter int unsigned CW        = 8,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 210,
  parameter int unsigned H_SYNC    = 1,
  parameter int unsigned H_BP      = 45,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 22,
  parameter int unsigned V_SYNC    = 1,
  parameter int unsigned V_BP      = 22,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned FETCH_LAT = 2
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iLoading,
  input  logic [1:0]    iMode,
  input  logic [3*CW-1:0] iFill,
  input  logic [3*CW-1:0] iPIX_DATA,
  output logic          oFETCH_EN,
  output logic [10:0]   oFETCH_X,
  output logic [9:0]    oFETCH_Y,
  output logic          oNewFrame,
  output logic          oEndFrame,
  output logic          oHD,
  output logic          oVD,
  output logic          oDE,
  output logic [CW-1:0] oLCD_R,
  output logic [CW-1:0] oLCD_G,
  output logic [CW-1:0] oLCD_B
);

  localparam int unsigned HTot  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VTot  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned BarW  = H_ACTIVE / 8;

  localparam logic [10:0] HTotM1 = 11'(HTot - 1);
  localparam logic [10:0] HStart = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HEnd   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] HSyncW = 11'(H_SYNC);
  localparam logic [10:0] BarWM1 = 11'(BarW - 1);
  localparam logic [9:0]  VTotM1 = 10'(VTot - 1);
  localparam logic [9:0]  VStart = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEnd   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  VSyncW = 10'(V_SYNC);
  localparam logic [CW-1:0] Max  = {CW{1'b1}};
  localparam logic [CW-1:0] Zero = {CW{1'b0}};

  if (HTot > 2047) begin : gHTotCheck
    $error("H_TOT does not fit the 11-bit x counter");
  end
  if (VTot > 1023) begin : gVTotCheck
    $error("V_TOT does not fit the 10-bit y counter");
  end
  if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : gLatCheck
    $error("FETCH_LAT must be 1..8");
  end
  if (H_ACTIVE < 8) begin : gBarCheck
    $error("H_ACTIVE must be at least 8 for colour bars");
  end

  typedef enum logic [1:0] {StNoData, StLoad, StRun} stateT;
  typedef enum logic [2:0] {SrcWhite, SrcYellow, SrcFetch, SrcBars, SrcFill, SrcBlack} srcT;

  logic [10:0] xCnt;
  logic [9:0]  yCnt;
  logic        active, atOrigin, hdRaw, vdRaw, fetchEn;
  stateT       stateQ, stateD;
  logic [1:0]  modeQ, modeD;
  logic        pendQ, pendD;
  srcT         src;
  logic [10:0] barCnt;
  logic [2:0]  barIdx;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      xCnt <= '0;
      yCnt <= '0;
    end else if (xCnt == HTotM1) begin
      xCnt <= '0;
      yCnt <= (yCnt == VTotM1) ? '0 : yCnt + 10'd1;
    end else begin
      xCnt <= xCnt + 11'd1;
    end
  end

  always_comb begin
    active   = (xCnt >= HStart) && (xCnt <= HEnd) && (yCnt >= VStart) && (yCnt <= VEnd);
    atOrigin = (xCnt == 11'd0) && (yCnt == 10'd0);
    hdRaw    = xCnt < HSyncW;
    vdRaw    = yCnt < VSyncW;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stateQ <= StNoData;
      modeQ  <= 2'd0;
      pendQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      modeQ  <= modeD;
      pendQ  <= pendD;
    end
  end

  // Mode and reload only take effect at (0,0) so a frame is never mixed.
  always_comb begin
    stateD = stateQ;
    modeD  = modeQ;
    pendD  = pendQ;
    unique case (stateQ)
      StNoData: if (iLoading) stateD = StLoad;
      StLoad:   if (atOrigin && !iLoading) stateD = StRun;
      StRun: begin
        pendD = pendQ | iLoading;
        if (atOrigin) begin
          modeD = iMode;
          if (pendD) begin
            stateD = StLoad;
            pendD  = 1'b0;
          end
        end
      end
      default: stateD = StNoData;
    endcase
  end

  always_comb begin
    src = SrcBlack;
    unique case (stateQ)
      StNoData: src = SrcWhite;
      StLoad:   src = SrcYellow;
      default: begin
        unique case (modeQ)
          2'd0:    src = SrcFetch;
          2'd1:    src = SrcBars;
          2'd2:    src = SrcFill;
          default: src = SrcBlack;
        endcase
      end
    endcase
  end

  always_comb begin
    fetchEn   = active && (stateQ == StRun) && (modeQ == 2'd0);
    oFETCH_EN = fetchEn;
    oFETCH_X  = fetchEn ? xCnt - HStart : 11'd0;
    oFETCH_Y  = fetchEn ? yCnt - VStart : 10'd0;
    oNewFrame = atOrigin;
    oEndFrame = (xCnt == HEnd) && (yCnt == VEnd);
  end

  // Bar index advances every BarW active pixels; the last bar absorbs the remainder.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      barCnt <= '0;
      barIdx <= '0;
    end else if (!active) begin
      barCnt <= '0;
      barIdx <= '0;
    end else if (barIdx != 3'd7) begin
      if (barCnt == BarWM1) begin
        barCnt <= '0;
        barIdx <= barIdx + 3'd1;
      end else begin
        barCnt <= barCnt + 11'd1;
      end
    end
  end

  logic [FETCH_LAT:0] deSr, hdSr, vdSr;
  srcT                srcSr [FETCH_LAT];
  logic [2:0]         barSr [FETCH_LAT];
  logic [3*CW-1:0]    pixSel, lcdQ;
  logic [2:0]         barRgb;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      deSr <= '0;
      hdSr <= '0;
      vdSr <= '0;
      for (int i = 0; i < int'(FETCH_LAT); i++) begin
        srcSr[i] <= SrcWhite;
        barSr[i] <= 3'd0;
      end
    end else begin
      deSr     <= {deSr[FETCH_LAT-1:0], active};
      hdSr     <= {hdSr[FETCH_LAT-1:0], hdRaw};
      vdSr     <= {vdSr[FETCH_LAT-1:0], vdRaw};
      srcSr[0] <= src;
      barSr[0] <= barIdx;
      for (int i = 1; i < int'(FETCH_LAT); i++) begin
        srcSr[i] <= srcSr[i-1];
        barSr[i] <= barSr[i-1];
      end
    end
  end

  always_comb begin
    barRgb = 3'b000;
    unique case (barSr[FETCH_LAT-1])
      3'd0:    barRgb = 3'b111;
      3'd1:    barRgb = 3'b110;
      3'd2:    barRgb = 3'b011;
      3'd3:    barRgb = 3'b010;
      3'd4:    barRgb = 3'b101;
      3'd5:    barRgb = 3'b100;
      3'd6:    barRgb = 3'b001;
      default: barRgb = 3'b000;
    endcase
  end

  // Selection happens in the cycle the fetched data arrives, aligned with stage FETCH_LAT-1.
  always_comb begin
    pixSel = '0;
    unique case (srcSr[FETCH_LAT-1])
      SrcWhite:  pixSel = {Max, Max, Max};
      SrcYellow: pixSel = {Max, Max, Zero};
      SrcFetch:  pixSel = iPIX_DATA;
      SrcBars:   pixSel = {{CW{barRgb[2]}}, {CW{barRgb[1]}}, {CW{barRgb[0]}}};
      SrcFill:   pixSel = iFill;
      default:   pixSel = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      lcdQ <= '0;
    end else begin
      lcdQ <= deSr[FETCH_LAT-1] ? pixSel : '0;
    end
  end

  always_comb begin
    oDE    = deSr[FETCH_LAT];
    oHD    = SYNC_POL ? hdSr[FETCH_LAT] : ~hdSr[FETCH_LAT];
    oVD    = SYNC_POL ? vdSr[FETCH_LAT] : ~vdSr[FETCH_LAT];
    oLCD_R = lcdQ[3*CW-1:2*CW];
    oLCD_G = lcdQ[2*CW-1:CW];
    oLCD_B = lcdQ[CW-1:0];
  end

endmodule

// File: tb/tb_mtl_display_engine.sv
// Bench for mtl_display_engine: two instances (latency 2 / active-low, latency 5 / active-high)
// on a shrunken raster, checked each cycle against a frame/position model plus literal pins.
module tb_mtl_display_engine;

  localparam int HA = 20, HFP = 4, HSY = 2, HBP = 3;
  localparam int VA = 6, VFP = 2, VSY = 1, VBP = 2;
  localparam int HTot = HSY + HBP + HA + HFP;
  localparam int VTot = VSY + VBP + VA + VFP;
  localparam int HS = HSY + HBP;
  localparam int VS = VSY + VBP;
  localparam int F = HTot * VTot;
  localparam int BarW = HA / 8;
  localparam int LatA = 2;
  localparam int LatB = 5;
  localparam logic [23:0] Fill = 24'h3C81E7;
  localparam logic [23:0] BarRgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        iCLK = 1'b0;
  logic        iRST_n, iLoading;
  logic [1:0]  iMode;
  logic [23:0] iFill, pixA, pixB;

  logic        enA, nfA, efA, hdA, vdA, deA;
  logic [10:0] xA;
  logic [9:0]  yA;
  logic [7:0]  rA, gA, bA;
  logic        enB, nfB, efB, hdB, vdB, deB;
  logic [10:0] xB;
  logic [9:0]  yB;
  logic [7:0]  rB, gB, bB;

  always #5 iCLK = ~iCLK;

  mtl_display_engine #(
    .CW(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0), .FETCH_LAT(LatA)
  ) dutA (
    .iCLK(iCLK), .iRST_n(iRST_n), .iLoading(iLoading), .iMode(iMode), .iFill(iFill),
    .iPIX_DATA(pixA), .oFETCH_EN(enA), .oFETCH_X(xA), .oFETCH_Y(yA), .oNewFrame(nfA),
    .oEndFrame(efA), .oHD(hdA), .oVD(vdA), .oDE(deA), .oLCD_R(rA), .oLCD_G(gA), .oLCD_B(bA)
  );

  mtl_display_engine #(
    .CW(8), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1), .FETCH_LAT(LatB)
  ) dutB (
    .iCLK(iCLK), .iRST_n(iRST_n), .iLoading(iLoading), .iMode(iMode), .iFill(iFill),
    .iPIX_DATA(pixB), .oFETCH_EN(enB), .oFETCH_X(xB), .oFETCH_Y(yB), .oNewFrame(nfB),
    .oEndFrame(efB), .oHD(hdB), .oVD(vdB), .oDE(deB), .oLCD_R(rB), .oLCD_G(gB), .oLCD_B(bB)
  );

  function automatic logic [23:0] pixHash(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb ^ 8'h5A, yb + 8'h11, xb + yb + 8'h33};
  endfunction

  // Pixel memory: answers each request exactly FETCH_LAT cycles later, garbage otherwise.
  logic [21:0] reqA [LatA];
  logic [21:0] reqB [LatB];
  always_ff @(posedge iCLK) begin
    reqA[0] <= {enA, xA, yA};
    reqB[0] <= {enB, xB, yB};
    for (int i = 1; i < LatA; i++) reqA[i] <= reqA[i-1];
    for (int i = 1; i < LatB; i++) reqB[i] <= reqB[i-1];
  end
  assign pixA = reqA[LatA-1][21] ?
                pixHash(int'(reqA[LatA-1][20:10]), int'(reqA[LatA-1][9:0])) : 24'hC3C3C3;
  assign pixB = reqB[LatB-1][21] ?
                pixHash(int'(reqB[LatB-1][20:10]), int'(reqB[LatB-1][9:0])) : 24'hC3C3C3;

  int checks = 0, failures = 0;
  int c;                    // cycles since reset release
  int scr, mMode;           // screen: 0 no data, 1 loading, 2 running
  bit pend;
  int srcHist [64];         // 0 white, 1 yellow, 2 fetched, 3 bars, 4 fill, 5 black
  int deCnt, vdLow, hdLow, efCnt;
  bit seenWhite, seenYellow, seenFetch, seenFetchPix;

  function automatic int posX(input int m);
    return m % HTot;
  endfunction
  function automatic int posY(input int m);
    return (m / HTot) % VTot;
  endfunction
  function automatic bit isAct(input int m);
    if (m < 0) return 1'b0;
    return posX(m) >= HS && posX(m) < HS + HA && posY(m) >= VS && posY(m) < VS + VA;
  endfunction

  function automatic logic [23:0] colourOf(input int code, input int xa, input int ya);
    int bar;
    case (code)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return pixHash(xa, ya);
      3: begin
        bar = xa / BarW;
        if (bar > 7) bar = 7;
        return BarRgb[bar];
      end
      4: return Fill;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  task automatic modelReset();
    c = 0; scr = 0; mMode = 0; pend = 0;
    srcHist[0] = 0;
    deCnt = 0; vdLow = 0; hdLow = 0; efCnt = 0;
  endtask

  // Screen content for the next cycle from the inputs held during cycle c.
  task automatic advance();
    bit origin;
    origin = (c % F) == 0;
    if (scr == 0) begin
      if (iLoading) scr = 1;
    end else if (scr == 1) begin
      if (origin && !iLoading) scr = 2;
    end else begin
      if (iLoading) pend = 1;
      if (origin) begin
        mMode = int'(iMode);
        if (pend) begin
          scr = 1;
          pend = 0;
        end
      end
    end
    c++;
    srcHist[c % 64] = (scr == 0) ? 0 : (scr == 1) ? 1 : 2 + mMode;
  endtask

  task automatic compareDut(input string t, input int lat, input bit pol, input logic en,
                            input logic [10:0] fx, input logic [9:0] fy, input logic nf,
                            input logic ef, input logic de, input logic hd, input logic vd,
                            input logic [23:0] rgb);
    int m;
    bit fe, expDe, hdOn, vdOn;
    logic [23:0] expRgb;
    m = c - lat - 1;
    fe = isAct(c) && srcHist[c % 64] == 2;
    expDe = isAct(m);
    hdOn = (m >= 0) && posX(m) < HSY;
    vdOn = (m >= 0) && posY(m) < VSY;
    expRgb = expDe ? colourOf(srcHist[m % 64], posX(m) - HS, posY(m) - VS) : 24'h0;
    chk({t, "_fetchEn"}, 32'(en), 32'(fe));
    chk({t, "_fetchX"}, 32'(fx), fe ? 32'(posX(c) - HS) : 32'd0);
    chk({t, "_fetchY"}, 32'(fy), fe ? 32'(posY(c) - VS) : 32'd0);
    chk({t, "_newFrame"}, 32'(nf), 32'((c % F) == 0));
    chk({t, "_endFrame"}, 32'(ef), 32'(posX(c) == HS + HA - 1 && posY(c) == VS + VA - 1));
    chk({t, "_de"}, 32'(de), 32'(expDe));
    chk({t, "_hd"}, 32'(hd), 32'(pol ? hdOn : !hdOn));
    chk({t, "_vd"}, 32'(vd), 32'(pol ? vdOn : !vdOn));
    chk({t, "_rgb"}, 32'(rgb), 32'(expRgb));
  endtask

  task automatic compareAll();
    int m, xa, ya, code;
    logic [23:0] rgbA;
    rgbA = {rA, gA, bA};
    compareDut("A", LatA, 1'b0, enA, xA, yA, nfA, efA, deA, hdA, vdA, rgbA);
    compareDut("B", LatB, 1'b1, enB, xB, yB, nfB, efB, deB, hdB, vdB, {rB, gB, bB});
    // Hand-computed pins on instance A, independent of colourOf().
    m = c - LatA - 1;
    if (isAct(m)) begin
      xa = posX(m) - HS;
      ya = posY(m) - VS;
      code = srcHist[m % 64];
      if (code == 3 && xa == 1) chk("A_bar1_white", 32'(rgbA), 32'hFFFFFF);
      if (code == 3 && xa == 2) chk("A_bar2_yellow", 32'(rgbA), 32'hFFFF00);
      if (code == 3 && xa == 13) chk("A_bar13_blue", 32'(rgbA), 32'h0000FF);
      if (code == 3 && xa == 19) chk("A_bar19_black", 32'(rgbA), 32'h000000);
      if (code == 0 && !seenWhite) begin
        seenWhite = 1;
        chk("A_white", 32'(rgbA), 32'hFFFFFF);
      end
      if (code == 1 && !seenYellow) begin
        seenYellow = 1;
        chk("A_yellow", 32'(rgbA), 32'hFFFF00);
      end
      if (code == 2 && xa == 0 && ya == 0 && !seenFetchPix) begin
        seenFetchPix = 1;
        chk("A_firstPix", 32'(rgbA), 32'h5A1133);
      end
    end
    if (isAct(c) && srcHist[c % 64] == 2 && !seenFetch) begin
      seenFetch = 1;
      chk("A_firstFetch", 32'({enA, xA, yA}), 32'({1'b1, 11'd0, 10'd0}));
    end
    deCnt += int'(deA);
    vdLow += int'(!vdA);
    hdLow += int'(!hdA);
    efCnt += int'(efB);
    if (c % F == F - 1) begin
      // 20x6 active pixels, one 29-cycle VD line, 2-cycle HD on each of 11 lines.
      chk("A_deFrame", 32'(deCnt), 32'd120);
      chk("A_vdFrame", 32'(vdLow), 32'd29);
      chk("A_hdFrame", 32'(hdLow), 32'd22);
      chk("B_endFrame", 32'(efCnt), 32'd1);
      deCnt = 0; vdLow = 0; hdLow = 0; efCnt = 0;
    end
  endtask

  task automatic tick();
    advance();
    @(negedge iCLK);
    compareAll();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    bit found;
    iRST_n = 1'b0; iLoading = 1'b0; iMode = 2'd0; iFill = Fill;
    repeat (3) @(negedge iCLK);
    iRST_n = 1'b1;
    modelReset();
    compareAll();
    run(2 * F);                           // no data: white

    run(100);
    iLoading = 1'b1; run(3); iLoading = 1'b0;
    run(2 * F);                           // loading, then fetched frames

    iMode = 2'd1; run(2 * F);             // colour bars from the next frame
    iMode = 2'd0; run(F);
    iMode = 2'd2; run(2 * F);             // fetching frame completes, then fill

    iLoading = 1'b1; run(5); iLoading = 1'b0; iMode = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3 * F && !found; i++) begin
      tick();
      if (scr == 2 && mMode == 0 && posX(c) == HS + 8 && posY(c) == VS + 2) found = 1'b1;
    end
    chk("reach_fetch_line", 32'(found), 32'd1);

    // Asynchronous reset mid-line, away from any clock edge.
    #3 iRST_n = 1'b0;
    #1;
    chk("A_rst_out", 32'({enA, xA, yA, deA, hdA, vdA, rA, gA, bA}),
        32'({1'b0, 11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'd0}));
    chk("B_rst_out", 32'({enB, xB, yB, deB, hdB, vdB, rB, gB, bB}),
        32'({1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 24'd0}));
    @(negedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    modelReset();
    compareAll();
    run(F + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
